direction_validator: RTL

Walks the board memory from a newly placed piece's address in one direction and decides whether that direction encloses a run of opponent pieces. In flip mode it also overwrites that run with the mover's colour. It sits directly downstream of the new-move controller, which loads a step and pulses a start once per direction. It shares the board RAM port with the datapath and returns a done pulse plus a per-direction valid bit.

---
 rtl/direction_validator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/direction_validator.sv
// Walks the board from a placed piece in one direction, checking for an
// enclosed opponent run and optionally flipping it to the mover's colour.
module direction_validator #(
  parameter int BOARD_CELLS = 100,
  parameter int MAX_RUN     = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ld,
  input  logic [4:0] step_in,
  input  logic [6:0] origin_in,
  input  logic [1:0] player_in,
  input  logic       flip_in,
  input  logic       enable,
  output logic [6:0] mem_addr_o,
  input  logic [1:0] mem_rdata_i,
  output logic       mem_wr_o,
  output logic [1:0] mem_wdata_o,
  output logic       s_done_o,
  output logic       dir_status_o
);

  localparam logic [6:0] LAST_CELL = 7'(BOARD_CELLS - 1);
  localparam logic [2:0] RUN_MAX   = 3'(MAX_RUN);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    FLIP,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [4:0] step_q;
  logic [6:0] origin_q;
  logic [1:0] player_q;
  logic       flip_q;
  logic [6:0] cur_q, cur_n;
  logic [2:0] count_q, count_n;
  logic       valid_q, valid_n;
  logic       oob_q, oob_n;

  logic [6:0] addr_n;
  logic       wr_n;
  logic       done_n;
  logic       status_n;

  logic [4:0] step_e;
  logic [6:0] origin_e;
  logic [6:0] start_addr;
  logic [6:0] first_addr;
  logic [6:0] next_cur;
  logic [1:0] opp;
  logic [2:0] count_inc;
  logic       is_opp;
  logic       is_own;

  // ld in the enable cycle must steer the very first address
  assign step_e     = ld ? step_in : step_q;
  assign origin_e   = ld ? origin_in : origin_q;
  assign start_addr = origin_e + {{2{step_e[4]}}, step_e};
  assign first_addr = origin_q + {{2{step_q[4]}}, step_q};
  assign next_cur   = cur_q + {{2{step_q[4]}}, step_q};
  assign opp        = player_q ^ 2'b11;
  assign count_inc  = count_q + 3'd1;
  assign is_opp     = (mem_rdata_i == opp);
  assign is_own     = (mem_rdata_i == player_q);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_n = READ;
      READ:  state_n = oob_q ? DONE : CHECK;
      CHECK: begin
        unique case (1'b1)
          is_opp:  state_n = (count_inc == RUN_MAX) ? DONE : READ;
          is_own:  state_n = (count_q != 3'd0 && flip_q) ? FLIP : DONE;
          default: state_n = DONE;
        endcase
      end
      FLIP:  if (count_q == 3'd1) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cur_n    = cur_q;
    count_n  = count_q;
    valid_n  = valid_q;
    oob_n    = oob_q;
    addr_n   = mem_addr_o;
    wr_n     = 1'b0;
    done_n   = 1'b0;
    status_n = dir_status_o;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          cur_n    = start_addr;
          count_n  = 3'd0;
          status_n = 1'b0;
          oob_n    = (start_addr > LAST_CELL);
          if (start_addr <= LAST_CELL) addr_n = start_addr;
        end
      end
      READ: begin
        if (oob_q) begin
          valid_n  = 1'b0;
          done_n   = 1'b1;
          status_n = 1'b0;
        end
      end
      CHECK: begin
        unique case (1'b1)
          is_opp: begin
            count_n = count_inc;
            if (count_inc == RUN_MAX) begin
              valid_n  = 1'b0;
              done_n   = 1'b1;
              status_n = 1'b0;
            end else begin
              cur_n = next_cur;
              oob_n = (next_cur > LAST_CELL);
              if (next_cur <= LAST_CELL) addr_n = next_cur;
            end
          end
          is_own: begin
            valid_n = (count_q != 3'd0);
            if (count_q != 3'd0 && flip_q) begin
              cur_n  = first_addr;
              addr_n = first_addr;
              wr_n   = 1'b1;
            end else begin
              done_n   = 1'b1;
              status_n = (count_q != 3'd0);
            end
          end
          default: begin
            valid_n  = 1'b0;
            done_n   = 1'b1;
            status_n = 1'b0;
          end
        endcase
      end
      FLIP: begin
        count_n = count_q - 3'd1;
        if (count_q == 3'd1) begin
          done_n   = 1'b1;
          status_n = valid_q;
        end else begin
          cur_n  = next_cur;
          addr_n = next_cur;
          wr_n   = 1'b1;
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      step_q       <= '0;
      origin_q     <= '0;
      player_q     <= '0;
      flip_q       <= 1'b0;
      cur_q        <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      oob_q        <= 1'b0;
      mem_addr_o   <= '0;
      mem_wr_o     <= 1'b0;
      mem_wdata_o  <= '0;
      s_done_o     <= 1'b0;
      dir_status_o <= 1'b0;
    end else begin
      if (ld) begin
        step_q      <= step_in;
        origin_q    <= origin_in;
        player_q    <= player_in;
        flip_q      <= flip_in;
        mem_wdata_o <= player_in;
      end
      cur_q        <= cur_n;
      count_q      <= count_n;
      valid_q      <= valid_n;
      oob_q        <= oob_n;
      mem_addr_o   <= addr_n;
      mem_wr_o     <= wr_n;
      s_done_o     <= done_n;
      dir_status_o <= status_n;
    end
  end

endmodule
